// File: rtl/rob_ptr_ctrl_if.sv
// Renaming/commit handshake bundle for the ROB pointer controller.
// master = pipeline side driving requests; slave = the pointer controller.
interface rob_ptr_ctrl_if #(
  parameter int ROB_DEPTH    = 16,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
);
  localparam int AW = $clog2(ROB_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(ALLOC_WIDTH + 1);
  localparam int RW = $clog2(COMMIT_WIDTH + 1);

  logic [NW-1:0]                   alloc_num;
  logic                            alloc_ready;
  logic [ALLOC_WIDTH-1:0][AW-1:0]  rob_addr;
  logic [RW-1:0]                   commit_num;
  logic                            flush;
  logic [AW-1:0]                   head;
  logic [AW-1:0]                   tail;
  logic [CW-1:0]                   count;
  logic                            full;
  logic                            empty;

  modport master (
    output alloc_num, commit_num, flush,
    input  alloc_ready, rob_addr, head, tail, count, full, empty
  );

  modport slave (
    input  alloc_num, commit_num, flush,
    output alloc_ready, rob_addr, head, tail, count, full, empty
  );
endinterface

// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail/occupancy tracker; ROB_PTR_STAT_EN adds a saturating stall counter.
// Latency: rob_addr is combinational from tail; pointer/count updates visible next cycle.
// Backpressure: alloc_ready drops when free < ALLOC_WIDTH; refused requests must be held.
module rob_ptr_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  rob_ptr_ctrl_if.slave rob
`ifdef ROB_PTR_STAT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);
  localparam int AW = $clog2(ROB_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ROB_DEPTH);
  localparam logic [CW-1:0] AWID_C  = CW'(ALLOC_WIDTH);

  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] free_n;
  logic [CW-1:0] commit_req;
  logic [CW-1:0] c_eff;
  logic [CW-1:0] alloc_amt;
  logic          ready;
  logic          alloc_fire;

  // Readiness looks only at registered occupancy, so a same-cycle commit never frees space.
  always_comb begin
    free_n     = DEPTH_C - count_q;
    ready      = (free_n >= AWID_C);
    alloc_fire = ready && (rob.alloc_num != '0) && !rob.flush;
    alloc_amt  = alloc_fire ? CW'(rob.alloc_num) : '0;
    commit_req = CW'(rob.commit_num);
    c_eff      = (commit_req > count_q) ? count_q : commit_req;
  end

  always_comb begin
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      rob.rob_addr[i] = tail_q + AW'(i);
    end
  end

  assign rob.alloc_ready = ready;
  assign rob.head        = head_q;
  assign rob.tail        = tail_q;
  assign rob.count       = count_q;
  assign rob.full        = (count_q == DEPTH_C);
  assign rob.empty       = (count_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn || rob.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + c_eff[AW-1:0];
      tail_q  <= tail_q + alloc_amt[AW-1:0];
      count_q <= count_q + alloc_amt - c_eff;
    end
  end

`ifdef ROB_PTR_STAT_EN
  // Survives flush so stalls can be accumulated across pipeline recoveries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if ((rob.alloc_num != '0) && !ready && !rob.flush && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed bench for rob_ptr_ctrl at ROB_DEPTH=8, ALLOC_WIDTH=2, COMMIT_WIDTH=2.
module tb_rob_ptr_ctrl;
  localparam int D = 8;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rob_ptr_ctrl_if #(.ROB_DEPTH(D), .ALLOC_WIDTH(2), .COMMIT_WIDTH(2)) bus ();

`ifdef ROB_PTR_STAT_EN
  logic [31:0] stall_cycles;
`endif

  rob_ptr_ctrl #(.ROB_DEPTH(D), .ALLOC_WIDTH(2), .COMMIT_WIDTH(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rob    (bus.slave)
`ifdef ROB_PTR_STAT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // {head, tail, count, full, empty, alloc_ready}
  wire [12:0] st = {bus.head, bus.tail, bus.count, bus.full, bus.empty, bus.alloc_ready};

  function automatic logic [12:0] exp_st(input int h, input int t, input int c);
    logic [2:0] hh;
    logic [2:0] tt;
    logic [3:0] cc;
    hh = h[2:0];
    tt = t[2:0];
    cc = c[3:0];
    return {hh, tt, cc, (c == D), (c == 0), (c <= D - 2)};
  endfunction

  function automatic logic [5:0] addr_pair(input int a0, input int a1);
    logic [2:0] x0;
    logic [2:0] x1;
    x0 = a0[2:0];
    x1 = a1[2:0];
    return {x1, x0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int an, input int cn, input logic fl);
    bus.alloc_num  = an[1:0];
    bus.commit_num = cn[1:0];
    bus.flush      = fl;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(2, 2, 1'b0);
    cyc();
    cyc();
    n_checks++;
    if (st !== exp_st(0, 0, 0)) begin n_fail++; $display("FAIL reset_state act=%h exp=%h", st, exp_st(0, 0, 0)); end
    n_checks++;
    if (bus.rob_addr !== addr_pair(0, 1)) begin n_fail++; $display("FAIL reset_addr act=%h exp=%h", bus.rob_addr, addr_pair(0, 1)); end
    resetn = 1'b1;
    drive(0, 0, 1'b0);
    cyc();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(2, 0, 1'b0);
      #1;
      n_checks++;
      if (bus.rob_addr !== addr_pair(2 * k, 2 * k + 1)) begin
        n_fail++; $display("FAIL fill_addr%0d act=%h exp=%h", k, bus.rob_addr, addr_pair(2 * k, 2 * k + 1));
      end
      cyc();
      n_checks++;
      if (st !== exp_st(0, (2 * k + 2) % D, 2 * k + 2)) begin
        n_fail++; $display("FAIL fill_state%0d act=%h exp=%h", k, st, exp_st(0, (2 * k + 2) % D, 2 * k + 2));
      end
    end
    cyc();
    cyc();
    n_checks++;
    if (st !== exp_st(0, 0, 8)) begin n_fail++; $display("FAIL fill_refused act=%h exp=%h", st, exp_st(0, 0, 8)); end
  endtask

  task automatic test_boundary();
    drive(0, 1, 1'b0);
    cyc();
    n_checks++;
    if (st !== exp_st(1, 0, 7)) begin n_fail++; $display("FAIL bnd_commit act=%h exp=%h", st, exp_st(1, 0, 7)); end
    drive(1, 0, 1'b0);
    #1;
    n_checks++;
    if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL bnd_ready7 act=%b exp=0", bus.alloc_ready); end
    cyc();
    n_checks++;
    if (st !== exp_st(1, 0, 7)) begin n_fail++; $display("FAIL bnd_noalloc act=%h exp=%h", st, exp_st(1, 0, 7)); end
    drive(1, 1, 1'b0);
    cyc();
    n_checks++;
    if (st !== exp_st(2, 0, 6)) begin n_fail++; $display("FAIL bnd_freed act=%h exp=%h", st, exp_st(2, 0, 6)); end
    drive(0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    drive(0, 0, 1'b1);
    cyc();
    drive(2, 0, 1'b0); cyc();
    drive(2, 2, 1'b0); cyc();
    drive(2, 2, 1'b0); cyc();
    drive(0, 2, 1'b0); cyc();
    n_checks++;
    if (st !== exp_st(6, 6, 0)) begin n_fail++; $display("FAIL wrap_setup act=%h exp=%h", st, exp_st(6, 6, 0)); end
    drive(2, 0, 1'b0);
    #1;
    n_checks++;
    if (bus.rob_addr !== addr_pair(6, 7)) begin n_fail++; $display("FAIL wrap_addr67 act=%h exp=%h", bus.rob_addr, addr_pair(6, 7)); end
    cyc();
    n_checks++;
    if (st !== exp_st(6, 0, 2)) begin n_fail++; $display("FAIL wrap_state1 act=%h exp=%h", st, exp_st(6, 0, 2)); end
    drive(2, 2, 1'b0);
    #1;
    n_checks++;
    if (bus.rob_addr !== addr_pair(0, 1)) begin n_fail++; $display("FAIL wrap_addr01 act=%h exp=%h", bus.rob_addr, addr_pair(0, 1)); end
    cyc();
    n_checks++;
    if (st !== exp_st(0, 2, 2)) begin n_fail++; $display("FAIL wrap_state2 act=%h exp=%h", st, exp_st(0, 2, 2)); end
    drive(0, 0, 1'b0);
  endtask

  task automatic test_clamp_flush();
    drive(0, 1, 1'b0);
    cyc();
    n_checks++;
    if (st !== exp_st(1, 2, 1)) begin n_fail++; $display("FAIL clamp_pre act=%h exp=%h", st, exp_st(1, 2, 1)); end
    drive(0, 2, 1'b0);
    cyc();
    n_checks++;
    if (st !== exp_st(2, 2, 0)) begin n_fail++; $display("FAIL clamp_state act=%h exp=%h", st, exp_st(2, 2, 0)); end
    drive(0, 2, 1'b0);
    cyc();
    n_checks++;
    if (st !== exp_st(2, 2, 0)) begin n_fail++; $display("FAIL clamp_empty act=%h exp=%h", st, exp_st(2, 2, 0)); end
    drive(2, 0, 1'b0);
    cyc();
    drive(2, 1, 1'b1);
    cyc();
    n_checks++;
    if (st !== exp_st(0, 0, 0)) begin n_fail++; $display("FAIL flush_state act=%h exp=%h", st, exp_st(0, 0, 0)); end
    n_checks++;
    if (bus.rob_addr !== addr_pair(0, 1)) begin n_fail++; $display("FAIL flush_addr act=%h exp=%h", bus.rob_addr, addr_pair(0, 1)); end
    drive(0, 0, 1'b0);
    cyc();
  endtask

`ifdef ROB_PTR_STAT_EN
  task automatic test_stats();
    drive(2, 0, 1'b0);
    for (int k = 0; k < 4; k++) cyc();
    n_checks++;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stat_fill act=%0d exp=0", stall_cycles); end
    drive(1, 0, 1'b0);
    for (int k = 0; k < 5; k++) cyc();
    n_checks++;
    if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stat_five act=%0d exp=5", stall_cycles); end
    drive(2, 0, 1'b1);
    cyc();
    n_checks++;
    if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stat_flush act=%0d exp=5", stall_cycles); end
    drive(2, 0, 1'b0);
    for (int k = 0; k < 4; k++) cyc();
    for (int k = 0; k < 3; k++) cyc();
    n_checks++;
    if (stall_cycles !== 32'd8) begin n_fail++; $display("FAIL stat_eight act=%0d exp=8", stall_cycles); end
    resetn = 1'b0;
    cyc();
    n_checks++;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stat_reset act=%0d exp=0", stall_cycles); end
    resetn = 1'b1;
    drive(0, 0, 1'b0);
    cyc();
  endtask
`endif

  initial begin
    resetn = 1'b0;
    drive(0, 0, 1'b0);
    test_reset();
    test_fill();
    test_boundary();
    test_wrap();
    test_clamp_flush();
`ifdef ROB_PTR_STAT_EN
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
